muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two operands read from the register file's rs1/rs2 ports and the destination index.
- Produces a 32-bit result plus destination index, destined for the register file write port (rd value / rd select).
- Single-issue, start/busy/done handshake. One operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request. Sampled on a rising edge only while busy_o=0.
- funct3_i  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  32  operand A (dividend / multiplicand).
- rs2_i  in  32  operand B (divisor / multiplier).
- selRd_i  in  5  destination register index, carried through unchanged.
- busy_o  out  1  high from the cycle after acceptance until the done cycle, inclusive.
- done_o  out  1  single-cycle pulse; rd_o and selRd_o are valid in this cycle.
- rd_o  out  32  result.
- selRd_o  out  5  destination index of the completed operation.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE.
  - busy_o=0, done_o=0, rd_o=0, selRd_o=0.
  - All internal accumulators and counters cleared.
- Reset mid-operation: the in-flight operation is discarded and no done_o is produced. After rst_i rises, the unit accepts a new start on the first edge.
- States:
  - IDLE: if start_i=1 at an edge, latch funct3_i, rs1_i, rs2_i and selRd_i.
    - If a fast-path condition holds, go to DONE.
    - Otherwise go to CALC with counter=0.
  - CALC: one iteration per cycle; counter increments. After the 32nd iteration (counter=31), go to FIX.
  - FIX: apply sign correction and select the result half; go to DONE.
  - DONE: done_o=1 and busy_o=1 for one cycle; go to IDLE.
- Latency (start high in cycle 0):
  - Normal ops: done_o in cycle 34.
  - Fast path: done_o in cycle 1.
- Handshake:
  - start_i is ignored while busy_o=1, including in the DONE cycle.
  - A start in the cycle immediately after done_o is accepted.
  - Operand inputs only need to be valid in the acceptance cycle.
- rd_o and selRd_o hold their last values after done_o until the next done_o; they update only in the done cycle.
- Multiply:
  - Operands are converted to magnitudes according to signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - 32-step shift-add into a 64-bit unsigned product.
  - FIX negates the full 64-bit product if the result sign is negative (exactly one signed operand negative).
  - MUL returns bits [31:0]; the others return [63:32].
- Divide:
  - Magnitudes are taken for DIV/REM; raw values for DIVU/REMU.
  - 32-step restoring division gives a 32-bit quotient and remainder.
  - FIX sign rules:
    - Quotient is negated if operand signs differ.
    - Remainder takes the dividend's sign.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Fast path (no CALC):
  - Divisor = 0: quotient = 0xFFFFFFFF (all div variants); remainder = rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000, with no overflow in intermediate widths.
- selRd=0 is passed through unchanged; discarding x0 writes is the register file's job.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, selRd=5, start in cycle 0 -> done_o only in cycle 34, rd_o=0xFFFFFFEB, selRd_o=5, busy_o high in cycles 1..34.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> done_o in cycle 1, rd_o=0xFFFFFFFF. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM same operands -> 0.
- Start MUL; pulse start_i with different operands in cycles 5 and 34 -> both ignored, a single done_o with the original result. A new start in cycle 35 is accepted and completes in cycle 69.
- Start DIV; drive rst_i low in cycle 10 -> all outputs 0 immediately, no done_o afterwards. After release, REMU 9/4 completes with rd_o=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide sharing one 64-bit accumulator, with a fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      selRd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] rd_o,
  output logic [4:0]      selRd_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      sel_q;
  logic [AW-1:0]   acc_q;
  logic [XLEN-1:0] opb_q;
  logic            neg_q, neg_r;

  logic            a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, hi, lo;
  logic [XLEN:0]   mul_sum, shifted;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [AW-1:0]   acc_step, prod_fix;
  logic [XLEN-1:0] fast_res, fix_res, res_c;

  // Operand signedness and magnitudes for the request at the inputs
  always_comb begin
    a_sgn = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    b_sgn = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
    a_neg = a_sgn & rs1_i[XLEN-1];
    b_neg = b_sgn & rs2_i[XLEN-1];
    a_mag = a_neg ? XLEN'(-rs1_i) : rs1_i;
    b_mag = b_neg ? XLEN'(-rs2_i) : rs2_i;
    div0  = (rs2_i == '0);
    ovf   = funct3_i[2] & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
  end

  // One iteration: hi holds partial product / remainder, lo holds multiplier / dividend-quotient
  always_comb begin
    hi       = acc_q[AW-1:XLEN];
    lo       = acc_q[XLEN-1:0];
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : '0);
    shifted  = {hi, lo[XLEN-1]};
    ge       = (shifted >= {1'b0, opb_q});
    diff     = shifted[XLEN-1:0] - opb_q;
    acc_step = '0;
    if (op_q[2]) begin
      acc_step = ge ? {diff, lo[XLEN-2:0], 1'b1} : {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, lo[XLEN-1:1]};
    end
  end

  // Result selection for the fast path (from inputs) and for FIX (from accumulator)
  always_comb begin
    prod_fix = neg_q ? AW'(-acc_q) : acc_q;
    fast_res = '0;
    fix_res  = '0;
    if (funct3_i[1]) fast_res = div0 ? rs1_i : '0;
    else             fast_res = div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    if (op_q[2]) begin
      if (op_q[1]) fix_res = neg_r ? XLEN'(-hi) : hi;
      else         fix_res = neg_q ? XLEN'(-lo) : lo;
    end else begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[AW-1:XLEN];
    end
    res_c = (state_q == S_IDLE) ? fast_res : fix_res;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (funct3_i[2] && (div0 || ovf)) ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      op_q    <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      rd_o    <= '0;
      selRd_o <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        op_q  <= funct3_i;
        sel_q <= selRd_i;
        acc_q <= {{XLEN{1'b0}}, a_mag};
        opb_q <= b_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt_q <= '0;
      end else if (state_q == S_CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CW'(1);
      end
      busy_o <= (state_d != S_IDLE);
      done_o <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        rd_o    <= res_c;
        selRd_o <= (state_q == S_IDLE) ? selRd_i : sel_q;
      end
    end
  end

endmodule
